fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset; SHALL be word aligned.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  byte address of the requested instruction.
REQ-006 imem_rdata  input  32  instruction word; valid in any cycle where imem_ready=1.
REQ-007 imem_ready  input  1  memory has accepted the request and returned data this cycle.
REQ-008 pc_src  input  1  branch taken, from the controller (Branch & zero).
REQ-009 jump  input  1  jump, from the controller.
REQ-010 stall  input  1  downstream not ready; hold the current instruction.
REQ-011 instr  output  32  instruction register (IR).
REQ-012 instr_valid  output  1  IR holds an instruction for decode/execute this cycle.
REQ-013 opcode  output  6  instr[31:26], combinational from IR.
REQ-014 funct  output  6  instr[5:0], combinational from IR.
REQ-015 imm_ext  output  32  sign-extended instr[15:0], combinational.
REQ-016 pc  output  32  address of the instruction in IR.
REQ-017 pc_plus4  output  32  pc + 4, modulo 2^32.

Function
REQ-018 FSM SHALL have exactly two states, FETCH and EXEC.
REQ-019 FETCH: imem_req=1, imem_addr=pc, instr_valid=0.
REQ-020 FETCH and imem_ready=1: IR <= imem_rdata, next state EXEC.
REQ-021 FETCH and imem_ready=0: remain in FETCH; pc and imem_addr held stable.
REQ-022 EXEC: imem_req=0, instr_valid=1.
REQ-023 EXEC and stall=1: remain in EXEC; IR and pc held.
REQ-024 EXEC and stall=0: pc <= next_pc, next state FETCH.
REQ-025 next_pc priority: jump=1 -> {pc_plus4[31:28], instr[25:0], 2'b00}; else pc_src=1 -> pc_plus4 + (imm_ext << 2); else pc_plus4.
REQ-026 jump=1 and pc_src=1 together: jump target SHALL win.
REQ-027 Branch target arithmetic SHALL be 32-bit modulo 2^32; carries discarded.
REQ-028 pc 32'hFFFF_FFFC sequential: next pc SHALL be 32'h0000_0000.
REQ-029 In FETCH, pc_src, jump and stall SHALL be ignored.
REQ-030 imem_ready while imem_req=0 SHALL be ignored.
REQ-031 Minimum latency: 2 cycles per instruction (imem_ready=1 in the first FETCH cycle, stall=0).
REQ-032 pc and pc_plus4 SHALL change only on the FETCH entry edge following EXEC.

Reset
REQ-033 reset_n=0 SHALL immediately, without waiting for clk, force state=FETCH, pc=RESET_PC, instr=32'h0, instr_valid=0.
REQ-034 During reset, imem_req SHALL be 0. From the first rising edge after reset_n goes high, the block SHALL be in FETCH with imem_req=1 and imem_addr=RESET_PC.
REQ-035 Reset asserted in any state, including a stalled EXEC or a pending FETCH, SHALL discard the in-flight instruction.

Verification
REQ-036 Release reset with imem_ready=1 and stall=0 -> imem_addr sequence 0x0, 0x4, 0x8, each held 1 FETCH cycle, instr_valid high on every 2nd cycle.
REQ-037 pc=0x10, IR=0x1000FFFF, pc_src=1 in EXEC -> next imem_addr=0x10.
REQ-038 pc=0x1000_0020, IR=0x0800_0040, jump=1 and pc_src=1 in EXEC -> next imem_addr=0x1000_0100.
REQ-039 imem_ready low for 3 FETCH cycles -> imem_addr stable for 4 cycles, instr_valid rises in cycle 5.
REQ-040 stall=1 for 2 EXEC cycles -> instr, pc and instr_valid=1 held 3 cycles; pc advances only after stall drops.
REQ-041 reset_n pulsed low mid-cycle during stalled EXEC -> instr_valid=0 and pc=RESET_PC before the next clk edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Two-state instruction fetch unit: requests a word at pc, holds it in IR for
// execution, then advances pc (sequential, branch or jump) on leaving EXEC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        pc_src,
  input  logic        jump,
  input  logic        stall,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] imm_ext,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        state_dbg
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] next_pc;
  logic        take_ir;
  logic        advance;

  // Handshake: a read completes in the cycle where imem_req=1 and imem_ready=1;
  // imem_addr is held until then, and imem_ready is ignored while imem_req=0.
  // Downstream consumes IR in a cycle where instr_valid=1 and stall=0.

  assign pc        = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign instr     = ir_q;
  assign opcode    = ir_q[31:26];
  assign funct     = ir_q[5:0];
  assign imm_ext   = {{16{ir_q[15]}}, ir_q[15:0]};
  assign imem_addr = pc_q;
  assign state_dbg = (state == EXEC);

  // Jump wins over branch; all arithmetic wraps at 32 bits.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
    end else if (pc_src) begin
      next_pc = pc_plus4 + {imm_ext[29:0], 2'b00};
    end
  end

  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    take_ir     = 1'b0;
    advance     = 1'b0;
    case (state)
      FETCH: begin
        // Gated by reset_n so no request leaks out while reset is held.
        imem_req = reset_n;
        if (imem_ready) begin
          take_ir    = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          advance    = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
      pc_q  <= RESET_PC;
      ir_q  <= 32'h0;
    end else begin
      state <= state_next;
      if (take_ir) begin
        ir_q <= imem_rdata;
      end
      if (advance) begin
        pc_q <= next_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: next-pc vector table, hand-written multi-cycle
// sequences, and random traffic checked against a transaction-level model.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        pc_src;
  logic        jump;
  logic        stall;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] imm_ext;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        state_dbg;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .pc_src      (pc_src),
    .jump        (jump),
    .stall       (stall),
    .instr       (instr),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .funct       (funct),
    .imm_ext     (imm_ext),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: does IR hold an instruction, its address, its word
  logic        m_have;
  logic [31:0] m_pc;
  logic [31:0] m_ir;

  typedef struct {
    logic [31:0] rd;
    logic        j;
    logic        b;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_next(input logic j, input logic b);
    logic [31:0]        seq;
    logic signed [31:0] off;
    seq = m_pc + 32'd4;
    off = 32'($signed(m_ir[15:0])) * 4;
    if (j) return {seq[31:28], m_ir[25:0], 2'b00};
    if (b) return seq + off;
    return seq;
  endfunction

  // Called just after a rising edge: drive, check before the next edge, advance model.
  task automatic tick(input logic rdy, input logic [31:0] rd, input logic j,
                      input logic b, input logic st);
    imem_ready = rdy;
    imem_rdata = rd;
    jump       = j;
    pc_src     = b;
    stall      = st;
    #2;
    chk("instr_valid", 32'(instr_valid), 32'(m_have));
    chk("state_dbg", 32'(state_dbg), 32'(m_have));
    chk("imem_req", 32'(imem_req), 32'(!m_have));
    if (!m_have) chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("instr", instr, m_ir);
    chk("opcode", 32'(opcode), 32'(m_ir[31:26]));
    chk("funct", 32'(funct), 32'(m_ir[5:0]));
    chk("imm_ext", imm_ext, {{16{m_ir[15]}}, m_ir[15:0]});
    @(posedge clk);
    if (!m_have) begin
      if (rdy) begin
        m_ir   = rd;
        m_have = 1'b1;
      end
    end else if (!st) begin
      m_pc   = model_next(j, b);
      m_have = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_state", 32'(state_dbg), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_have  = 1'b0;
    m_pc    = 32'h0;
    m_ir    = 32'h0;
  endtask

  initial begin
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    jump       = 1'b0;
    pc_src     = 1'b0;
    stall      = 1'b0;
    m_have     = 1'b0;
    m_pc       = 32'h0;
    m_ir       = 32'h0;

    tbl[0]  = '{32'h0000_0020, 1'b0, 1'b0, 32'h0000_0004};
    tbl[1]  = '{32'h0000_0020, 1'b0, 1'b0, 32'h0000_0008};
    tbl[2]  = '{32'h1234_5678, 1'b0, 1'b0, 32'h0000_000C};
    tbl[3]  = '{32'h0000_0000, 1'b0, 1'b0, 32'h0000_0010};
    tbl[4]  = '{32'h1000_FFFF, 1'b0, 1'b1, 32'h0000_0010};
    tbl[5]  = '{32'h1000_0003, 1'b0, 1'b1, 32'h0000_0020};
    tbl[6]  = '{32'h1000_0003, 1'b0, 1'b0, 32'h0000_0024};
    tbl[7]  = '{32'h0800_0100, 1'b1, 1'b0, 32'h0000_0400};
    tbl[8]  = '{32'h0BFF_FFFF, 1'b1, 1'b1, 32'h0FFF_FFFC};
    tbl[9]  = '{32'h0800_0008, 1'b1, 1'b0, 32'h1000_0020};
    tbl[10] = '{32'h0800_0040, 1'b1, 1'b1, 32'h1000_0100};
    tbl[11] = '{32'h1000_8000, 1'b0, 1'b1, 32'h0FFE_0104};
    tbl[12] = '{32'h0800_0000, 1'b1, 1'b0, 32'h0000_0000};
    tbl[13] = '{32'h1000_FFFE, 1'b0, 1'b1, 32'hFFFF_FFFC};
    tbl[14] = '{32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000};
    tbl[15] = '{32'h1000_FFFE, 1'b0, 1'b1, 32'hFFFF_FFFC};
    tbl[16] = '{32'h1000_0001, 1'b0, 1'b1, 32'h0000_0004};

    do_reset();

    // back-to-back fetches: 0x0, 0x4, 0x8 with instr_valid every 2nd cycle
    for (int i = 0; i < 6; i++) tick(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    chk("seq_pc", pc, 32'hC);

    do_reset();

    // next-pc table; controls driven opposite during FETCH must be ignored
    for (int i = 0; i < 17; i++) begin
      tick(1'b1, tbl[i].rd, ~tbl[i].j, ~tbl[i].b, 1'b1);
      chk("tbl_ir", instr, tbl[i].rd);
      tick(1'b1, ~tbl[i].rd, tbl[i].j, tbl[i].b, 1'b0);
      chk("tbl_pc", pc, tbl[i].exp_pc);
      chk("tbl_addr", imem_addr, tbl[i].exp_pc);
    end

    // stall held for two EXEC cycles at pc 0x4
    tick(1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("stall_pc_held", pc, 32'h4);
    chk("stall_ir_held", instr, 32'hCAFE_0001);
    tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("stall_pc_adv", pc, 32'h8);

    // memory not ready for three FETCH cycles at pc 0x8
    for (int i = 0; i < 3; i++) tick(1'b0, $urandom, 1'b1, 1'b1, 1'b1);
    chk("wait_not_valid", 32'(instr_valid), 32'h0);
    tick(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    chk("wait_valid", 32'(instr_valid), 32'h1);
    tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset during a stalled EXEC at pc 0xC
    tick(1'b1, 32'h2222_3333, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_pc", pc, 32'hC);
    #2;
    do_reset();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) < 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
